// File: rtl/sum_accumulator_pkg.sv
// Shared types and defaults for sum_accumulator.
package sum_accumulator_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int COUNT_BITS    = 8;
  localparam int DEF_NUM_BITS  = 4;
  localparam int DEF_ACC_BITS  = 8;
  localparam int DEF_BLOCK_LEN = 4;
endpackage

// File: rtl/sum_accumulator_adder_nbit.sv
// Parameterised ripple-carry adder: the 4-bit team adder widened to W bits.
module adder_nbit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         overflow
);
  logic c;

  always_comb begin
    sum = '0;
    c   = carry_in;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    overflow = c;
  end
endmodule

// File: rtl/sum_accumulator.sv
// Block accumulator: sums BLOCK_LEN samples, presents result with sticky overflow.
// Build option: define SUM_ACCUMULATOR_SATURATE_EN to clamp to all-ones on carry.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int NUM_BITS  = DEF_NUM_BITS,
  parameter int ACC_BITS  = DEF_ACC_BITS,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_BITS-1:0]   out_sum,
  output logic                  out_overflow,
  output logic [COUNT_BITS-1:0] sample_count
);
  state_t                state;
  logic [ACC_BITS-1:0]   acc, addend, sum, acc_nxt;
  logic                  carry, ovf, accept, last;
  logic [COUNT_BITS-1:0] count, count_nxt;

  assign accept = in_valid & in_ready;
  // Gate the sample so an idle (possibly X) bus never reaches the datapath.
  assign addend = accept ? ACC_BITS'(in_data) : '0;

  adder_nbit #(.W(ACC_BITS)) u_add (
    .a        (acc),
    .b        (addend),
    .carry_in (1'b0),
    .sum      (sum),
    .overflow (carry)
  );

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  assign acc_nxt = carry ? '1 : sum;
`else
  assign acc_nxt = sum;
`endif

  assign count_nxt = count + COUNT_BITS'(1);
  assign last      = (count_nxt == COUNT_BITS'(BLOCK_LEN));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc   <= addend;
          count <= COUNT_BITS'(1);
          if (BLOCK_LEN == 1) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (accept) begin
          acc   <= acc_nxt;
          ovf   <= ovf | carry;
          count <= count_nxt;
          if (last) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          acc       <= '0;
          count     <= '0;
          ovf       <= 1'b0;
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sum      = acc;
  assign out_overflow = ovf;
  assign sample_count = count;
endmodule
